// File: rtl/io_monitor_pkg.sv
// Shared defaults and the captured-entry layout for the IO monitor.
package io_monitor_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 16;
   localparam int DEF_SEL_W  = 4;
   localparam int DEF_DEPTH  = 16;
   localparam int DEF_CNT_W  = 32;

   localparam logic [DEF_ADDR_W-1:0] DEF_HALT_ADDR = '1;

   typedef struct packed {
      logic [DEF_SEL_W-1:0]  sel;
      logic [DEF_DATA_W-1:0] data;
   } entry_t;

endpackage

// File: rtl/io_monitor_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on rd_data_o
// without a read strobe. Storage has no reset; only the pointers do.
module io_monitor_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // A push into a full FIFO is only accepted when a pop frees the slot.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/io_monitor.sv
// Captures CPU IO strobes into a FIFO until the program halts.
// Optional watchdog enabled by defining IO_MONITOR_TIMEOUT_EN.
module io_monitor
   import io_monitor_pkg::*;
#(
   parameter int                DATA_W    = DEF_DATA_W,
   parameter int                ADDR_W    = DEF_ADDR_W,
   parameter int                SEL_W     = DEF_SEL_W,
   parameter int                DEPTH     = DEF_DEPTH,
   parameter logic [ADDR_W-1:0] HALT_ADDR = '1,
   parameter int                CNT_W     = DEF_CNT_W,
   parameter int                TIMEOUT   = 100000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic [ADDR_W-1:0]       rom_address,
   input  logic [SEL_W-1:0]        io_sel,
   input  logic [DATA_W-1:0]       io_data,
   input  logic                    io_output,
   input  logic [(2**SEL_W)-1:0]   ch_mask,
   input  logic                    rd_en,
   output logic [SEL_W+DATA_W-1:0] rd_data,
   output logic                    empty,
   output logic                    full,
   output logic                    overflow,
   output logic [7:0]              drop_count,
   output logic                    halted,
   output logic                    timeout,
   output logic [CNT_W-1:0]        cycle_count
);

   logic             io_q, io_d;
   logic             prime_q;
   logic             overflow_q, overflow_d;
   logic [7:0]       drop_count_q, drop_count_d;
   logic             halted_q, halted_d;
   logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
   logic             timeout_w;
   logic             capture, drop, fifo_full, fifo_empty;

   // prime_q suppresses a capture on the first edge after reset, so a
   // strobe already high at release is not mistaken for a rising edge.
   assign capture = io_output && !io_q && prime_q && ch_mask[io_sel] &&
                    !halted_q && !timeout_w && !clear;
   assign drop    = capture && fifo_full && !rd_en;

   io_monitor_fifo #(
      .WIDTH (SEL_W + DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (clear),
      .push_i    (capture),
      .wr_data_i ({io_sel, io_data}),
      .pop_i     (rd_en && !clear),
      .rd_data_o (rd_data),
      .empty_o   (fifo_empty),
      .full_o    (fifo_full)
   );

   always_comb begin
      io_d          = io_output;
      overflow_d    = overflow_q | drop;
      drop_count_d  = drop_count_q;
      halted_d      = halted_q | (rom_address == HALT_ADDR);
      cycle_count_d = cycle_count_q;
      if (drop && drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
      if (!halted_q && !timeout_w && cycle_count_q != {CNT_W{1'b1}})
         cycle_count_d = cycle_count_q + CNT_W'(1);
      if (clear) begin
         io_d          = 1'b0;
         overflow_d    = 1'b0;
         drop_count_d  = '0;
         halted_d      = 1'b0;
         cycle_count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         io_q          <= 1'b0;
         prime_q       <= 1'b0;
         overflow_q    <= 1'b0;
         drop_count_q  <= '0;
         halted_q      <= 1'b0;
         cycle_count_q <= '0;
      end else begin
         io_q          <= io_d;
         prime_q       <= 1'b1;
         overflow_q    <= overflow_d;
         drop_count_q  <= drop_count_d;
         halted_q      <= halted_d;
         cycle_count_q <= cycle_count_d;
      end
   end

`ifdef IO_MONITOR_TIMEOUT_EN
   logic timeout_q, timeout_d;

   // Compare against the next count so the flag and the final count
   // TIMEOUT-1 appear on the same edge.
   always_comb begin
      timeout_d = timeout_q |
                  (!halted_q && cycle_count_d == CNT_W'(TIMEOUT - 1));
      if (clear) timeout_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) timeout_q <= 1'b0;
      else      timeout_q <= timeout_d;
   end

   assign timeout_w = timeout_q;
`else
   assign timeout_w = 1'b0;
`endif

   assign empty       = fifo_empty;
   assign full        = fifo_full;
   assign overflow    = overflow_q;
   assign drop_count  = drop_count_q;
   assign halted      = halted_q;
   assign timeout     = timeout_w;
   assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_io_monitor.sv
// Directed bench for io_monitor: main instance with default parameters,
// second instance with TIMEOUT=20 for the watchdog and mid-run reset.
module tb_io_monitor;
   import io_monitor_pkg::*;

   logic        clk;
   logic        rst, clear, io_output, rd_en;
   logic [15:0] rom_address, ch_mask;
   logic [3:0]  io_sel;
   logic [7:0]  io_data;
   logic [11:0] rd_data;
   logic        empty, full, overflow, halted, timeout;
   logic [7:0]  drop_count;
   logic [31:0] cycle_count;

   logic        t_rst, t_io;
   logic [11:0] t_rd_data;
   logic        t_empty, t_full, t_overflow, t_halted, t_timeout;
   logic [7:0]  t_drop_count;
   logic [31:0] t_cycle_count;

   int errors = 0;
   int checks = 0;

   io_monitor dut (
      .clk(clk), .rst(rst), .clear(clear), .rom_address(rom_address),
      .io_sel(io_sel), .io_data(io_data), .io_output(io_output),
      .ch_mask(ch_mask), .rd_en(rd_en), .rd_data(rd_data), .empty(empty),
      .full(full), .overflow(overflow), .drop_count(drop_count),
      .halted(halted), .timeout(timeout), .cycle_count(cycle_count)
   );

   io_monitor #(.TIMEOUT(20)) dut_wd (
      .clk(clk), .rst(t_rst), .clear(1'b0), .rom_address(16'h0000),
      .io_sel(4'h1), .io_data(8'h5A), .io_output(t_io),
      .ch_mask(16'hFFFF), .rd_en(1'b0), .rd_data(t_rd_data), .empty(t_empty),
      .full(t_full), .overflow(t_overflow), .drop_count(t_drop_count),
      .halted(t_halted), .timeout(t_timeout), .cycle_count(t_cycle_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic strobe(input logic [3:0] s, input logic [7:0] d);
      @(negedge clk);
      io_sel = s; io_data = d; io_output = 1'b1;
      @(negedge clk);
      io_output = 1'b0;
      $display("strobe sel=%h data=%h empty=%b full=%b", s, d, empty, full);
   endtask

   task automatic pop();
      @(negedge clk);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      $display("pop    head=%h empty=%b", rd_data, empty);
   endtask

   task automatic test_reset();
      rst = 1'b0; clear = 1'b0; rom_address = 16'h0000; ch_mask = 16'hFFFF;
      io_sel = 4'h0; io_data = 8'h00; io_output = 1'b1; rd_en = 1'b0;
      t_rst = 1'b0; t_io = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b need 1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b need 0", full); end
      checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop: got %b/%0d need 0/0", overflow, drop_count); end
      checks++; if (halted !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b/%b need 0/0", halted, timeout); end
      checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d need 0", cycle_count); end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL release_high_strobe: empty got %b need 1", empty); end
      checks++; if (cycle_count !== 32'd3) begin errors++; $display("FAIL release_count: got %0d need 3", cycle_count); end
      io_output = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      @(negedge clk);
      io_sel = 4'h2; io_data = 8'h41; io_output = 1'b1;
      @(negedge clk);
      io_output = 1'b0;
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL push_latency: empty got %b need 0", empty); end
      checks++; if (rd_data !== 12'h241) begin errors++; $display("FAIL basic_head1: got %h need 241", rd_data); end
      strobe(4'h2, 8'h42);
      pop();
      checks++; if (rd_data !== 12'h242) begin errors++; $display("FAIL basic_head2: got %h need 242", rd_data); end
      pop();
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty: got %b need 1", empty); end
   endtask

   task automatic test_mask();
      ch_mask = 16'hFFFB;
      strobe(4'h2, 8'h22);
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mask_ignore: empty got %b need 1", empty); end
      strobe(4'h3, 8'h33);
      checks++; if (empty !== 1'b0 || rd_data !== 12'h333) begin errors++; $display("FAIL mask_capture: got empty=%b %h need 0 333", empty, rd_data); end
      pop();
      ch_mask = 16'hFFFF;
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 17; i++) begin
         strobe(4'h1, 8'h10 + 8'(i));
         if (i == 15) begin
            checks++; if (full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL full_at_16: got full=%b ovf=%b need 1 0", full, overflow); end
         end
      end
      checks++; if (full !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL overflow_flags: got full=%b ovf=%b need 1 1", full, overflow); end
      checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL overflow_count: got %0d need 1", drop_count); end
      checks++; if (rd_data !== 12'h110) begin errors++; $display("FAIL overflow_head: got %h need 110", rd_data); end
   endtask

   task automatic test_full_push_pop();
      logic [11:0] exp;
      @(negedge clk);
      io_sel = 4'h5; io_data = 8'hAA; io_output = 1'b1; rd_en = 1'b1;
      @(negedge clk);
      io_output = 1'b0; rd_en = 1'b0;
      checks++; if (full !== 1'b1 || drop_count !== 8'd1) begin errors++; $display("FAIL fullpp_flags: got full=%b drops=%0d need 1 1", full, drop_count); end
      for (int i = 1; i < 16; i++) begin
         exp = {4'h1, 8'h10 + 8'(i)};
         checks++; if (rd_data !== exp) begin errors++; $display("FAIL drain_%0d: got %h need %h", i, rd_data, exp); end
         pop();
      end
      checks++; if (rd_data !== 12'h5AA) begin errors++; $display("FAIL fullpp_tail: got %h need 5aa", rd_data); end
      pop();
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fullpp_empty: got %b need 1", empty); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      io_sel = 4'h6; io_data = 8'h66; io_output = 1'b1; rd_en = 1'b1;
      @(negedge clk);
      io_output = 1'b0; rd_en = 1'b0;
      checks++; if (empty !== 1'b0 || rd_data !== 12'h666) begin errors++; $display("FAIL pushpop_empty: got empty=%b %h need 0 666", empty, rd_data); end
      pop();
      pop();
      strobe(4'h6, 8'h67);
      checks++; if (rd_data !== 12'h667 || full !== 1'b0) begin errors++; $display("FAIL pop_on_empty: got %h full=%b need 667 0", rd_data, full); end
      pop();
   endtask

   task automatic test_clear();
      strobe(4'h4, 8'h44);
      @(negedge clk);
      clear = 1'b1; io_sel = 4'h4; io_data = 8'h45; io_output = 1'b1;
      @(negedge clk);
      clear = 1'b0; io_output = 1'b0;
      checks++; if (empty !== 1'b1 || overflow !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL clear_state: got empty=%b ovf=%b drops=%0d need 1 0 0", empty, overflow, drop_count); end
      checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL clear_count: got %0d need 0", cycle_count); end
      @(negedge clk);
      checks++; if (empty !== 1'b1 || cycle_count !== 32'd1) begin errors++; $display("FAIL clear_after: got empty=%b count=%0d need 1 1", empty, cycle_count); end
   endtask

   task automatic test_halt();
      strobe(4'h7, 8'h77);
      for (int n = 0; n < 200 && cycle_count != 32'd50; n++) @(negedge clk);
      checks++; if (cycle_count !== 32'd50) begin errors++; $display("FAIL halt_wait: count got %0d need 50", cycle_count); end
      rom_address = 16'hFFFF;
      @(negedge clk);
      rom_address = 16'h0000;
      checks++; if (halted !== 1'b1 || cycle_count !== 32'd51) begin errors++; $display("FAIL halt_set: got halted=%b count=%0d need 1 51", halted, cycle_count); end
      repeat (5) @(negedge clk);
      checks++; if (cycle_count !== 32'd51) begin errors++; $display("FAIL halt_frozen: got %0d need 51", cycle_count); end
      strobe(4'h8, 8'h88);
      checks++; if (empty !== 1'b0 || rd_data !== 12'h777) begin errors++; $display("FAIL halt_readable: got empty=%b %h need 0 777", empty, rd_data); end
      pop();
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL halt_ignore: empty got %b need 1", empty); end
   endtask

   task automatic test_timeout();
      @(negedge clk);
      t_rst = 1'b1;
      repeat (10) @(negedge clk);
      checks++; if (t_timeout !== 1'b0 || t_cycle_count !== 32'd10) begin errors++; $display("FAIL wd_early: got to=%b count=%0d need 0 10", t_timeout, t_cycle_count); end
      repeat (20) @(negedge clk);
      @(negedge clk);
      t_io = 1'b1;
      @(negedge clk);
      t_io = 1'b0;
      $display("wd strobe timeout=%b count=%0d empty=%b", t_timeout, t_cycle_count, t_empty);
`ifdef IO_MONITOR_TIMEOUT_EN
      checks++; if (t_timeout !== 1'b1 || t_cycle_count !== 32'd19) begin errors++; $display("FAIL wd_fire: got to=%b count=%0d need 1 19", t_timeout, t_cycle_count); end
      checks++; if (t_empty !== 1'b1) begin errors++; $display("FAIL wd_blocks: empty got %b need 1", t_empty); end
`else
      checks++; if (t_timeout !== 1'b0 || t_cycle_count !== 32'd32) begin errors++; $display("FAIL wd_off: got to=%b count=%0d need 0 32", t_timeout, t_cycle_count); end
      checks++; if (t_empty !== 1'b0 || t_rd_data !== 12'h15A) begin errors++; $display("FAIL wd_off_capture: got empty=%b %h need 0 15a", t_empty, t_rd_data); end
`endif
      #2 t_rst = 1'b0;
      #1;
      checks++; if (t_empty !== 1'b1 || t_full !== 1'b0 || t_timeout !== 1'b0 || t_halted !== 1'b0) begin errors++; $display("FAIL midrun_flags: got e=%b f=%b to=%b h=%b need 1 0 0 0", t_empty, t_full, t_timeout, t_halted); end
      checks++; if (t_cycle_count !== 32'd0 || t_overflow !== 1'b0 || t_drop_count !== 8'd0) begin errors++; $display("FAIL midrun_counts: got count=%0d ovf=%b drops=%0d need 0 0 0", t_cycle_count, t_overflow, t_drop_count); end
      @(negedge clk);
      t_rst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_mask();
      test_overflow();
      test_full_push_pop();
      test_back_to_back();
      test_clear();
      test_halt();
      test_timeout();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
